// File: rtl/tcm_port_arbiter_if.sv
// Two-master TCM port bundle: M0 (core LSU), M1 (loader/DMA) and the
// single-ported TCM. Signal suffixes are from the arbiter's point of view.
interface tcm_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  m0_req_i;
    logic [3:0]            m0_wr_i;
    logic [31:0]           m0_addr_i;
    logic [31:0]           m0_data_i;
    logic                  m1_req_i;
    logic [3:0]            m1_wr_i;
    logic [31:0]           m1_addr_i;
    logic [31:0]           m1_data_i;
    logic                  m1_lock_i;
    logic                  m0_ack_o;
    logic                  m1_ack_o;
    logic                  m0_rvalid_o;
    logic                  m1_rvalid_o;
    logic                  m0_err_o;
    logic                  m1_err_o;
    logic [31:0]           m0_data_o;
    logic [31:0]           m1_data_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [31:0]           ram_data_o;
    logic [3:0]            ram_wr_o;
    logic [31:0]           ram_data_i;

    modport slave (
        input  m0_req_i, m0_wr_i, m0_addr_i, m0_data_i,
        input  m1_req_i, m1_wr_i, m1_addr_i, m1_data_i, m1_lock_i,
        output m0_ack_o, m1_ack_o, m0_rvalid_o, m1_rvalid_o,
        output m0_err_o, m1_err_o, m0_data_o, m1_data_o,
        output ram_addr_o, ram_data_o, ram_wr_o,
        input  ram_data_i
    );

    modport master (
        output m0_req_i, m0_wr_i, m0_addr_i, m0_data_i,
        output m1_req_i, m1_wr_i, m1_addr_i, m1_data_i, m1_lock_i,
        input  m0_ack_o, m1_ack_o, m0_rvalid_o, m1_rvalid_o,
        input  m0_err_o, m1_err_o, m0_data_o, m1_data_o,
        input  ram_addr_o, ram_data_o, ram_wr_o,
        output ram_data_i
    );
endinterface

// File: rtl/tcm_port_arbiter.sv
// Combinational two-master arbiter for a single TCM port with M1 burst
// locking bounded by MAX_BURST against a waiting M0, and a 1-deep response tracker.
module tcm_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    tcm_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M1_BURST
    } state_t;

    localparam logic [7:0] MAXB  = 8'(MAX_BURST);
    localparam logic [8:0] MAXB9 = 9'(MAX_BURST);

    state_t                state_q, state_d;
    logic [7:0]            burst_cnt_q, burst_cnt_d;
    logic                  m1_first;
    logic                  gnt0, gnt1, any_gnt;
    logic                  oor0, oor1, sel_oor;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_data_q, ram_data_d;
    logic [3:0]            ram_wr_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic                  rsp_own_q, rsp_own_d;
    logic                  rsp_err_q, rsp_err_d;

    // Any address bit above the TCM window makes the access out of range.
    function automatic logic out_of_range(input logic [31:0] a);
        logic r;
        r = 1'b0;
        for (int i = ADDR_WIDTH; i < 32; i++) begin
            r = r | a[i];
        end
        return r;
    endfunction

    assign oor0 = out_of_range(bus.m0_addr_i);
    assign oor1 = out_of_range(bus.m1_addr_i);

    // FSM next state, grant decision, TCM port mux and response capture.
    always_comb begin
        m1_first    = 1'b0;
        state_d     = S_IDLE;
        burst_cnt_d = 8'd0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_wr_d    = 4'd0;
        sel_oor     = 1'b0;

        unique case (state_q)
            S_M0:       m1_first = 1'b1;
            S_M1_BURST: m1_first = (burst_cnt_q < MAXB);
            default:    m1_first = 1'b0;
        endcase

        gnt1    = !rst_i && bus.m1_req_i && (!bus.m0_req_i || m1_first);
        gnt0    = !rst_i && bus.m0_req_i && !gnt1;
        any_gnt = gnt0 || gnt1;

        if (gnt1) begin
            if (bus.m1_lock_i && (({1'b0, burst_cnt_q} + 9'd1) < MAXB9)) begin
                state_d = S_M1_BURST;
            end else begin
                state_d = S_M1;
            end
        end else if (gnt0) begin
            state_d = S_M0;
        end

        if (state_d == S_M1_BURST) begin
            burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
        end

        if (gnt1) begin
            ram_addr_d = {2'b00, bus.m1_addr_i[ADDR_WIDTH-1:2]};
            ram_data_d = bus.m1_data_i;
            sel_oor    = oor1;
            ram_wr_d   = oor1 ? 4'd0 : bus.m1_wr_i;
        end else if (gnt0) begin
            ram_addr_d = {2'b00, bus.m0_addr_i[ADDR_WIDTH-1:2]};
            ram_data_d = bus.m0_data_i;
            sel_oor    = oor0;
            ram_wr_d   = oor0 ? 4'd0 : bus.m0_wr_i;
        end

        rsp_vld_d = any_gnt;
        rsp_own_d = gnt1;
        rsp_err_d = any_gnt && sel_oor;
    end

    // State, burst counter, held TCM fields and response tracker registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= 8'd0;
            ram_addr_q  <= '0;
            ram_data_q  <= 32'd0;
            rsp_vld_q   <= 1'b0;
            rsp_own_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_own_q   <= rsp_own_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.m0_ack_o    = gnt0;
    assign bus.m1_ack_o    = gnt1;
    assign bus.ram_addr_o  = ram_addr_d;
    assign bus.ram_data_o  = ram_data_d;
    assign bus.ram_wr_o    = ram_wr_d;

    assign bus.m0_rvalid_o = rsp_vld_q && !rsp_own_q;
    assign bus.m1_rvalid_o = rsp_vld_q && rsp_own_q;
    assign bus.m0_err_o    = bus.m0_rvalid_o && rsp_err_q;
    assign bus.m1_err_o    = bus.m1_rvalid_o && rsp_err_q;
    assign bus.m0_data_o   = (bus.m0_rvalid_o && !rsp_err_q) ? bus.ram_data_i : 32'd0;
    assign bus.m1_data_o   = (bus.m1_rvalid_o && !rsp_err_q) ? bus.ram_data_i : 32'd0;

endmodule
